// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU program-flow logic.
//   seq_state_t    : sequencer states (IDLE, RUN, ARMED, HALT)
//   PC_W_DEFAULT   : default program counter width
//   BR_TARGET_W    : width of the absolute branch target carried by the ALU
//   STATS_W        : width of the optional taken-branch counter
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  localparam int PC_W_DEFAULT = 10;
  localparam int BR_TARGET_W  = 9;
  localparam int STATS_W      = 16;

endpackage

// File: rtl/branch_sequencer_if.sv
// Bus between instruction decode/ALU and the branch sequencer.
//   master : decode side; drives start/hold and per-instruction decode flags
//   slave  : sequencer; drives pc and status flags back
// With BRANCH_SEQ_STATS_EN defined, the bus also carries br_taken_cnt.
interface branch_sequencer_if #(
  parameter int PC_W = cpu_pkg::PC_W_DEFAULT
);
  import cpu_pkg::*;

  logic                   start;
  logic                   hold;
  logic                   cmp_valid;
  logic                   cmp_eq;
  logic                   br_valid;
  logic [BR_TARGET_W-1:0] br_target;
  logic                   halt_i;
  logic [PC_W-1:0]        pc;
  logic                   armed;
  logic                   jumped;
  logic                   running;
  logic                   done;
`ifdef BRANCH_SEQ_STATS_EN
  logic [STATS_W-1:0]     br_taken_cnt;

  modport master (
    output start, hold, cmp_valid, cmp_eq, br_valid, br_target, halt_i,
    input  pc, armed, jumped, running, done, br_taken_cnt
  );
  modport slave (
    input  start, hold, cmp_valid, cmp_eq, br_valid, br_target, halt_i,
    output pc, armed, jumped, running, done, br_taken_cnt
  );
`else
  modport master (
    output start, hold, cmp_valid, cmp_eq, br_valid, br_target, halt_i,
    input  pc, armed, jumped, running, done
  );
  modport slave (
    input  start, hold, cmp_valid, cmp_eq, br_valid, br_target, halt_i,
    output pc, armed, jumped, running, done
  );
`endif

endinterface

// File: rtl/branch_sequencer_pc_reg.sv
// Program counter register: load has priority over increment; neither
// asserted means hold. Increment wraps modulo 2^PC_W.
//   clk, rst_n : clock, async active-low reset (loads RESET_VAL)
//   load       : take load_val
//   inc        : advance by one
//   pc         : current program counter
module pc_reg #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-flow sequencer: owns the PC and turns the ALU's compare/branch
// instruction pair into a PC redirect.
//   clk, rst_n : clock, async active-low reset
//   bus        : branch_sequencer_if.slave
//                inputs  start, hold, cmp_valid, cmp_eq, br_valid,
//                        br_target, halt_i (decoded from instruction at pc)
//                outputs pc, armed, jumped, running, done
// Optional feature macro BRANCH_SEQ_STATS_EN: adds bus.br_taken_cnt, a
// saturating count of taken redirects, cleared on start and on reset.
// All outputs come from registers or the state register only.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_sequencer_if.slave   bus
);

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic            pc_load;
  logic            pc_inc;
  logic [PC_W-1:0] pc_load_val;
  logic            redirect;
  logic            restart;
  logic            jumped_q;
  logic            cmp_hit;

  assign cmp_hit = bus.cmp_valid && bus.cmp_eq;

  // Next-state and PC control. hold only gates the executing states;
  // IDLE/HALT react to start alone.
  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = START_ADDR;
    redirect    = 1'b0;
    restart     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_load   = 1'b1;
          restart   = 1'b1;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (bus.halt_i) begin
            state_nxt = HALT;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = cmp_hit ? ARMED : RUN;
          end
        end
      end
      ARMED: begin
        if (!bus.hold) begin
          if (bus.halt_i) begin
            state_nxt = HALT;
          end else if (bus.br_valid) begin
            state_nxt   = RUN;
            pc_load     = 1'b1;
            pc_load_val = PC_W'(bus.br_target);
            redirect    = 1'b1;
          end else begin
            // A fresh equal compare re-arms; anything else drops the branch.
            pc_inc    = 1'b1;
            state_nxt = cmp_hit ? ARMED : RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      jumped_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      // One-cycle pulse, independent of hold.
      jumped_q <= redirect;
    end
  end

  pc_reg #(
    .PC_W      (PC_W),
    .RESET_VAL (START_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (pc_load_val),
    .pc       (bus.pc)
  );

  assign bus.armed   = (state == ARMED);
  assign bus.jumped  = jumped_q;
  assign bus.running = (state == RUN) || (state == ARMED);
  assign bus.done    = (state == HALT);

`ifdef BRANCH_SEQ_STATS_EN
  logic [STATS_W-1:0] taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
    end else if (restart) begin
      taken_cnt <= '0;
    end else if (redirect && (taken_cnt != {STATS_W{1'b1}})) begin
      taken_cnt <= taken_cnt + STATS_W'(1);
    end
  end

  assign bus.br_taken_cnt = taken_cnt;
`endif

endmodule
